// File: rtl/uart_tx_fifo_feeder_if.sv
// Bus-side and UART-side signal bundle for the UART transmit FIFO feeder.
// The master modport is the producer/UART side; the slave modport is the feeder.
interface uart_tx_fifo_feeder_if #(
    parameter int DEPTH_BITS = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  flush;
    logic                  clear_errors;
    logic                  full;
    logic                  empty;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    logic                  launch_error;
    logic                  busy;
    logic                  transmit;
    logic [7:0]            tx_byte;
    logic                  is_transmitting;

    modport master (
        output wr_en, wr_data, flush, clear_errors, is_transmitting,
        input  full, empty, count, overflow, launch_error, busy, transmit, tx_byte
    );

    modport slave (
        input  wr_en, wr_data, flush, clear_errors, is_transmitting,
        output full, empty, count, overflow, launch_error, busy, transmit, tx_byte
    );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame, launches it with a
// one-cycle transmit pulse and waits for the UART busy flag to rise and fall.
module uart_tx_fifo_feeder #(
    parameter int DEPTH_BITS   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_fifo_feeder_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_BITS-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_BITS:0]    count, count_next;
    logic                   full, empty, overflow, launch_error;
    logic                   transmit, transmit_next;
    logic [7:0]             tx_byte;
    logic [TMO_W-1:0]       tmo, tmo_next;
    logic                   pop, push, drop, tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tmo      <= '0;
        end else begin
            state    <= state_next;
            transmit <= transmit_next;
            tmo      <= tmo_next;
        end
    end

    always_comb begin
        state_next    = state;
        transmit_next = 1'b0;
        tmo_next      = tmo;
        pop           = 1'b0;
        tmo_hit       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.is_transmitting && !bus.flush) begin
                    pop           = 1'b1;
                    transmit_next = 1'b1;
                    tmo_next      = '0;
                    state_next    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.is_transmitting) begin
                    state_next = WAIT_DONE;
                end else if (tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    // The launched byte is abandoned; the next queued byte goes out instead.
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.is_transmitting) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
    assign push = bus.wr_en && !bus.flush && (!full || pop);
    assign drop = bus.wr_en && !bus.flush && full && !pop;

    always_comb begin
        count_next = count;
        if (bus.flush)         count_next = '0;
        else if (push && !pop) count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            overflow     <= 1'b0;
            launch_error <= 1'b0;
            tx_byte      <= 8'h00;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == (DEPTH_BITS + 1)'(DEPTH));
            if (pop) tx_byte <= mem[rd_ptr];
            overflow     <= drop    | (overflow     & ~bus.clear_errors);
            launch_error <= tmo_hit | (launch_error & ~bus.clear_errors);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.launch_error = launch_error;
    assign bus.busy         = (state != IDLE) || (count != '0);
    assign bus.transmit     = transmit;
    assign bus.tx_byte      = tx_byte;
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a small UART busy-flag model.
module tb_uart_tx_fifo_feeder;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // UART model modes: 0 = answers each launch for HOLD cycles, 1 = stuck busy, 2 = never answers
    int   mode = 0;
    int   hold = 0;
    localparam int HOLD = 20;

    uart_tx_fifo_feeder_if #(.DEPTH_BITS(4)) bus ();

    uart_tx_fifo_feeder #(.DEPTH_BITS(4), .BUSY_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mode == 1) begin
            bus.is_transmitting = 1'b1;
            hold = 0;
        end else if (mode == 2) begin
            bus.is_transmitting = 1'b0;
            hold = 0;
        end else if (bus.transmit) begin
            bus.is_transmitting = 1'b1;
            hold = HOLD - 1;
        end else if (hold > 0) begin
            hold = hold - 1;
        end else begin
            bus.is_transmitting = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy) break;
            tick();
        end
    endtask

    initial begin
        logic [7:0] got [3];
        logic [4:0] cnt_at [3];
        int         npulse;
        logic       prev_tx;
        logic       wide;
        logic       empty_ok;

        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.clear_errors = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_transmit", bus.transmit, 0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_launch_error", bus.launch_error, 0);
        chk("rst_busy", bus.busy, 0);

        // single byte: launch two cycles after the write
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        chk("t1_count_after_push", bus.count, 1);
        chk("t1_no_pulse_yet", bus.transmit, 0);
        tick();
        chk("t1_transmit", bus.transmit, 1);
        chk("t1_tx_byte", bus.tx_byte, 8'hA5);
        chk("t1_empty_after_pop", bus.empty, 1);
        tick();
        chk("t1_pulse_one_cycle", bus.transmit, 0);
        chk("t1_busy_in_frame", bus.busy, 1);
        empty_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.empty) empty_ok = 1'b0;
            if (!bus.busy) break;
            tick();
        end
        chk("t1_busy_drop", bus.busy, 0);
        chk("t1_empty_throughout", empty_ok, 1);
        chk("t1_tx_byte_held", bus.tx_byte, 8'hA5);

        // three bytes queued behind a busy UART, then drained in order
        mode = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(i + 1);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("t2_count_3", bus.count, 3);
        mode = 0;
        npulse = 0;
        prev_tx = 1'b0;
        wide = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.transmit && prev_tx) wide = 1'b1;
            if (bus.transmit && npulse < 3) begin
                got[npulse] = bus.tx_byte;
                cnt_at[npulse] = bus.count;
                npulse++;
            end
            prev_tx = bus.transmit;
            if (npulse == 3 && !bus.busy) break;
        end
        chk("t2_pulses", npulse, 3);
        chk("t2_byte0", got[0], 8'h01);
        chk("t2_byte1", got[1], 8'h02);
        chk("t2_byte2", got[2], 8'h03);
        chk("t2_count_at_pulse0", cnt_at[0], 2);
        chk("t2_count_at_pulse1", cnt_at[1], 1);
        chk("t2_count_at_pulse2", cnt_at[2], 0);
        chk("t2_pulse_width", wide, 0);
        chk("t2_idle_after", bus.busy, 0);

        // fill to 16 with the UART stuck busy, 17th write overflows
        mode = 1;
        tick();
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            tick();
            if (i == 15) begin
                chk("t3_full_at_16", bus.full, 1);
                chk("t3_count_16", bus.count, 16);
                chk("t3_no_overflow_yet", bus.overflow, 0);
            end
        end
        bus.wr_en = 1'b0;
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_count_after_drop", bus.count, 16);
        bus.clear_errors = 1'b1;
        tick();
        bus.clear_errors = 1'b0;
        chk("t3_overflow_cleared", bus.overflow, 0);

        // full FIFO: UART frees up and a write arrives in the same cycle
        mode = 0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        bus.wr_en = 1'b0;
        chk("t4_transmit", bus.transmit, 1);
        chk("t4_tx_byte", bus.tx_byte, 8'h10);
        chk("t4_count_16", bus.count, 16);
        chk("t4_full", bus.full, 1);
        chk("t4_overflow", bus.overflow, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_flush_count", bus.count, 0);
        chk("t4_flush_empty", bus.empty, 1);
        wait_idle(60);
        chk("t4_idle", bus.busy, 0);

        // UART never answers: timeout after 8 cycles, next byte still launched
        mode = 2;
        tick();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        bus.wr_data = 8'h66;
        tick();
        bus.wr_en = 1'b0;
        chk("t5_transmit", bus.transmit, 1);
        chk("t5_tx_byte", bus.tx_byte, 8'h55);
        for (int i = 0; i < 7; i++) tick();
        chk("t5_no_error_at_7", bus.launch_error, 0);
        tick();
        chk("t5_error_at_8", bus.launch_error, 1);
        tick();
        chk("t5_next_transmit", bus.transmit, 1);
        chk("t5_next_tx_byte", bus.tx_byte, 8'h66);
        wait_idle(30);
        chk("t5_idle", bus.busy, 0);
        bus.clear_errors = 1'b1;
        tick();
        bus.clear_errors = 1'b0;
        chk("t5_error_cleared", bus.launch_error, 0);

        // flush while a frame is in flight
        mode = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'(8'hC0 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("t6_count_before_flush", bus.count, 4);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t6_flush_count", bus.count, 0);
        chk("t6_flush_empty", bus.empty, 1);
        chk("t6_frame_still_busy", bus.busy, 1);
        npulse = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.transmit) npulse++;
            if (!bus.busy) break;
            tick();
        end
        chk("t6_idle_after_frame", bus.busy, 0);
        chk("t6_no_more_pulses", npulse, 0);

        // reset while waiting for the UART to answer
        mode = 2;
        tick();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h77;
        tick();
        bus.wr_data = 8'h78;
        tick();
        bus.wr_en = 1'b0;
        chk("t6_launch_before_rst", bus.tx_byte, 8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_transmit", bus.transmit, 0);
        chk("t6_rst_tx_byte", bus.tx_byte, 8'h00);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_empty", bus.empty, 1);
        chk("t6_rst_full", bus.full, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_launch_error", bus.launch_error, 0);
        chk("t6_rst_overflow", bus.overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
